// File: rtl/keypad_matrix_scanner.sv
// Row-at-a-time keypad matrix scanner with press/release debounce, multi-key
// rejection and optional auto-repeat; emits an encoded key with a valid strobe.
module keypad_matrix_scanner #(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int SCAN_DIV     = 48000,
  parameter int DEBOUNCE     = 20,
  parameter int REPEAT_TICKS = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [COLS-1:0]               col,
  output logic [ROWS-1:0]               row_drive,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic [$clog2(ROWS)-1:0]       key_row,
  output logic [$clog2(COLS)-1:0]       key_col,
  output logic                          key_valid,
  output logic                          key_held,
  output logic                          multi_err
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int CODE_W = $clog2(ROWS*COLS);
  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE + 1);
  localparam int REP_W  = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_t;

  function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] idx);
    return {{(ROWS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [COLS-1:0] col_onehot(input logic [COL_W-1:0] idx);
    return {{(COLS-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [COL_W-1:0] col_encode(input logic [COLS-1:0] v);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (v[i]) idx = COL_W'(i);
      else      idx = idx;
    end
    return idx;
  endfunction

  logic [1:0]        rst_sync_r;
  logic              rst_n_s;
  logic [COLS-1:0]   col_meta_r, col_sync_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic              tick_s;
  state_t            state_r, state_nx;
  logic [ROW_W-1:0]  row_idx_r, row_idx_nx, row_next_s;
  logic [ROW_W-1:0]  cand_row_r, cand_row_nx, acc_row_s;
  logic [COL_W-1:0]  cand_col_r, cand_col_nx, acc_col_s;
  logic [DEB_W-1:0]  deb_cnt_r, deb_cnt_nx, rel_cnt_r, rel_cnt_nx;
  logic [REP_W-1:0]  rep_cnt_r, rep_cnt_nx;
  logic [ROWS-1:0]   row_drive_r;
  logic [CODE_W-1:0] key_code_r, key_code_nx;
  logic [ROW_W-1:0]  key_row_r, key_row_nx;
  logic [COL_W-1:0]  key_col_r, key_col_nx;
  logic              key_valid_r, key_valid_nx, key_held_r, key_held_nx;
  logic              multi_err_r, multi_err_nx;
  logic              accept_s, release_s, held_bit_s;

  // Reset synchroniser: asserts immediately, releases on a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_r <= 2'b00;
    else        rst_sync_r <= {rst_sync_r[0], 1'b1};
  end
  assign rst_n_s = rst_sync_r[1];

  // Column synchroniser and free-running scan-tick divider.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      col_meta_r <= '0;
      col_sync_r <= '0;
      div_cnt_r  <= '0;
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
      div_cnt_r  <= tick_s ? '0 : div_cnt_r + DIV_W'(1);
    end
  end

  assign tick_s     = (div_cnt_r == DIV_LAST);
  assign row_next_s = (row_idx_r == ROW_LAST) ? '0 : row_idx_r + ROW_W'(1);
  assign held_bit_s = col_sync_r[cand_col_r];

  // Next-state and next-output logic; everything advances only on a tick.
  always_comb begin
    state_nx     = state_r;
    row_idx_nx   = row_idx_r;
    cand_row_nx  = cand_row_r;
    cand_col_nx  = cand_col_r;
    deb_cnt_nx   = deb_cnt_r;
    rel_cnt_nx   = rel_cnt_r;
    rep_cnt_nx   = rep_cnt_r;
    key_code_nx  = key_code_r;
    key_row_nx   = key_row_r;
    key_col_nx   = key_col_r;
    key_valid_nx = 1'b0;
    key_held_nx  = key_held_r;
    multi_err_nx = 1'b0;
    accept_s     = 1'b0;
    release_s    = 1'b0;
    acc_row_s    = cand_row_r;
    acc_col_s    = cand_col_r;
    if (tick_s) begin
      case (state_r)
        ST_SCAN: begin
          if (col_sync_r == '0) begin
            row_idx_nx = row_next_s;
          end else if ($onehot(col_sync_r)) begin
            cand_row_nx = row_idx_r;
            cand_col_nx = col_encode(col_sync_r);
            deb_cnt_nx  = DEB_W'(1);
            acc_row_s   = row_idx_r;
            acc_col_s   = col_encode(col_sync_r);
            if (deb_cnt_nx == DEB_LAST) accept_s = 1'b1;
            else                        state_nx = ST_PRESS_DB;
          end else begin
            multi_err_nx = 1'b1;
            row_idx_nx   = row_next_s;
          end
        end
        ST_PRESS_DB: begin
          if (col_sync_r == col_onehot(cand_col_r)) begin
            deb_cnt_nx = deb_cnt_r + DEB_W'(1);
            if (deb_cnt_nx == DEB_LAST) accept_s = 1'b1;
            else                        accept_s = 1'b0;
          end else begin
            state_nx = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!held_bit_s) begin
            rel_cnt_nx = DEB_W'(1);
            if (rel_cnt_nx == DEB_LAST) release_s = 1'b1;
            else                        state_nx  = ST_REL_DB;
          end else if (REPEAT_TICKS != 0) begin
            rep_cnt_nx = rep_cnt_r + REP_W'(1);
            if (rep_cnt_nx == REP_LAST) begin
              key_valid_nx = 1'b1;
              rep_cnt_nx   = '0;
            end else begin
              key_valid_nx = 1'b0;
            end
          end else begin
            rep_cnt_nx = rep_cnt_r;
          end
        end
        ST_REL_DB: begin
          if (!held_bit_s) begin
            rel_cnt_nx = rel_cnt_r + DEB_W'(1);
            if (rel_cnt_nx == DEB_LAST) release_s = 1'b1;
            else                        release_s = 1'b0;
          end else begin
            state_nx = ST_HELD;
          end
        end
        default: state_nx = ST_SCAN;
      endcase
    end else begin
      state_nx = state_r;
    end
    if (accept_s) begin
      key_row_nx   = acc_row_s;
      key_col_nx   = acc_col_s;
      key_code_nx  = CODE_W'(acc_row_s) * CODE_W'(COLS) + CODE_W'(acc_col_s);
      key_valid_nx = 1'b1;
      key_held_nx  = 1'b1;
      rep_cnt_nx   = '0;
      state_nx     = ST_HELD;
    end else if (release_s) begin
      key_held_nx = 1'b0;
      row_idx_nx  = row_next_s;
      state_nx    = ST_SCAN;
    end else begin
      key_held_nx = key_held_nx;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= ST_SCAN;
      row_idx_r   <= '0;
      cand_row_r  <= '0;
      cand_col_r  <= '0;
      deb_cnt_r   <= '0;
      rel_cnt_r   <= '0;
      rep_cnt_r   <= '0;
      row_drive_r <= {{(ROWS-1){1'b0}}, 1'b1};
      key_code_r  <= '0;
      key_row_r   <= '0;
      key_col_r   <= '0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
      multi_err_r <= 1'b0;
    end else begin
      state_r     <= state_nx;
      row_idx_r   <= row_idx_nx;
      cand_row_r  <= cand_row_nx;
      cand_col_r  <= cand_col_nx;
      deb_cnt_r   <= deb_cnt_nx;
      rel_cnt_r   <= rel_cnt_nx;
      rep_cnt_r   <= rep_cnt_nx;
      row_drive_r <= row_onehot(row_idx_nx);
      key_code_r  <= key_code_nx;
      key_row_r   <= key_row_nx;
      key_col_r   <= key_col_nx;
      key_valid_r <= key_valid_nx;
      key_held_r  <= key_held_nx;
      multi_err_r <= multi_err_nx;
    end
  end

  assign row_drive = row_drive_r;
  assign key_code  = key_code_r;
  assign key_row   = key_row_r;
  assign key_col   = key_col_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;
  assign multi_err = multi_err_r;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised successor to the 4x4 keypad row scanner. It drives one row at a time, samples synchronised column inputs at a programmable scan rate, and debounces both press and release. It rejects multi-key presses, supports optional auto-repeat, and emits an encoded key with a one-cycle valid strobe. It sits between the keypad pins and the key decoder / display logic.

Parameters:
ROWS, 4, number of keypad rows driven (>=2)
COLS, 4, number of keypad columns sampled (>=2)
SCAN_DIV, 48000, clk cycles per scan tick (>=3, covers synchroniser plus settle)
DEBOUNCE, 20, consecutive stable ticks required to accept a press or a release (>=1)
REPEAT_TICKS, 0, ticks between auto-repeat strobes while held; 0 disables auto-repeat

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
col  input  COLS  raw column lines, 1 = key closed on driven row; asynchronous
row_drive  output  ROWS  one-hot, active-high row drive
key_code  output  $clog2(ROWS*COLS)  row*COLS+col of accepted key
key_row  output  $clog2(ROWS)  row index of accepted key
key_col  output  $clog2(COLS)  column index of accepted key
key_valid  output  1  one-cycle strobe: new press or auto-repeat
key_held  output  1  level: debounced key currently held
multi_err  output  1  one-cycle strobe: >1 column active on a scan tick

Behaviour:
- Reset (async assert, sync deassert):
  - FSM = SCAN; row_idx = 0; row_drive = one-hot row 0.
  - Divider, debounce and repeat counters = 0.
  - key_code, key_row, key_col, key_valid, key_held, multi_err = 0.
  - Reset mid-operation aborts any press with no strobe.
- col passes through a 2-FF synchroniser (col_s). All decisions use col_s.
- Divider counts 0..SCAN_DIV-1. tick = 1 on the cycle count == SCAN_DIV-1, then the counter wraps. It runs freely in every state.
- row_drive = one-hot(row_idx) at all times. row_idx changes only on a tick.
- SCAN state, on tick:
  - col_s == 0: row_idx advances, wrapping ROWS-1 -> 0.
  - col_s one-hot: latch row_idx and encoded column into cand_row/cand_col; deb_cnt = 1 (DEBOUNCE==1 goes straight to accept); enter PRESS_DB; row_idx frozen.
  - >1 bit set: multi_err = 1 for the following cycle; row_idx advances; stay in SCAN.
- PRESS_DB state, on tick:
  - col_s == one-hot(cand_col): deb_cnt++. When deb_cnt reaches DEBOUNCE:
    - load key_row/key_col/key_code from cand;
    - key_valid = 1 for exactly one cycle;
    - key_held = 1; rep_cnt = 0; enter HELD.
  - Any other value: return to SCAN with row_idx unchanged (rescans same row); no outputs change.
- HELD state (row frozen; only bit cand_col of col_s observed, other columns ignored), on tick:
  - bit low: rel_cnt = 1, enter REL_DB.
  - bit high and REPEAT_TICKS != 0: rep_cnt++. On reaching REPEAT_TICKS: key_valid pulses one cycle with unchanged key_code; rep_cnt = 0.
- REL_DB state, on tick:
  - bit low: rel_cnt++. On reaching DEBOUNCE: key_held = 0; row_idx advances; enter SCAN.
  - bit high: return to HELD; rep_cnt keeps its value; no strobe.
- key_code/key_row/key_col hold their last accepted value until the next accepted press.
- Strobes key_valid and multi_err are registered and are never asserted in the same cycle.
- Latency: key_valid asserts 1 clk after the DEBOUNCE-th matching tick.

Test Plan:
- Common config: SCAN_DIV=4, DEBOUNCE=3, REPEAT_TICKS=0. Drive col combinationally from row_drive to model the matrix.
- Reset / idle: hold reset low, release, col=0 -> row_drive=0001 and all outputs 0; row_drive then cycles 0001->0010->0100->1000->0001, changing every 4 clk.
- Clean press at row 2, col 1 (col=0010 while row_drive==0100), held 10 ticks -> exactly one key_valid, key_code=9, key_row=2, key_col=1, key_held=1, row_drive stays 0100.
- Bounce: press lasts 2 ticks then opens -> no key_valid, key_held=0; scanning resumes at row 2 and then advances.
- Multi-key: col=0110 while row_drive==0010 -> multi_err one-cycle pulse, no key_valid, row_drive advances to 0100.
- Release: key held, 1-tick open glitch, then fully open for 3 ticks -> key_held stays 1 through the glitch with no second key_valid; then key_held=0 and row_drive advances to the next row.
- Auto-repeat (REPEAT_TICKS=5): key held 22 ticks after acceptance -> 4 further key_valid pulses, 5 ticks apart, key_code unchanged; asserting reset mid-hold clears all outputs immediately.
